led_ind_drv: RTL and testbench

- Front-panel LED indicator driver for the FPGA tester. It is the output-side counterpart of the key input conditioner: it turns internal status (mode codes and one-cycle events) into human-visible LED patterns.
- Per LED it provides steady off/on, slow blink, fast blink, and a retriggerable minimum-visible flash for short events.
- All LEDs share one millisecond prescaler and common blink phase generators, so they blink in sync.

---
 rtl/led_ind_drv.sv | 181 ++++++++++++++++++
 tb/tb_led_ind_drv.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/led_ind_drv.sv
// -----------------------------------------------------------------------------
// led_ind_drv -- front-panel LED indicator driver.
//
// Turns per-LED mode codes and one-cycle event strobes into human-visible LED
// patterns. A shared millisecond prescaler drives common slow/fast blink phase
// generators so that every LED blinks in step. Each LED also owns a
// retriggerable flash stretcher that guarantees short events stay visible.
//
// Ports:
//   in_clk    system clock, rising edge
//   in_rst    asynchronous active-low reset
//   in_mode   2 bits per LED: 00 off, 01 on, 10 slow blink, 11 fast blink
//   in_flash  per-LED event strobe; (re)loads the flash stretcher
//   o_led     registered LED drive, inverted when LED_ACT_LOW != 0
// -----------------------------------------------------------------------------
module led_ind_drv #(
   parameter int N_LED        = 2,
   parameter int TICK_DIV     = 50000,
   parameter int SLOW_HALF_MS = 500,
   parameter int FAST_HALF_MS = 125,
   parameter int FLASH_MS     = 100,
   parameter int LED_ACT_LOW  = 0
) (
   input  logic                 in_clk,
   input  logic                 in_rst,
   input  logic [2*N_LED-1:0]   in_mode,
   input  logic [N_LED-1:0]     in_flash,
   output logic [N_LED-1:0]     o_led
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = (SLOW_HALF_MS > 1) ? $clog2(SLOW_HALF_MS) : 1;
   localparam int FW = (FAST_HALF_MS > 1) ? $clog2(FAST_HALF_MS) : 1;
   localparam int LW = (FLASH_MS > 0) ? $clog2(FLASH_MS + 1) : 1;

   localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0]    SLOW_LAST  = SW'(SLOW_HALF_MS - 1);
   localparam logic [FW-1:0]    FAST_LAST  = FW'(FAST_HALF_MS - 1);
   // Inactive output level; also the XOR mask applied at the output register.
   localparam logic [N_LED-1:0] POL_MASK   = (LED_ACT_LOW != 0) ? {N_LED{1'b1}} : {N_LED{1'b0}};

   logic [PW-1:0]    presc_q, presc_d;
   logic             tick_s;
   logic [SW-1:0]    slow_cnt_q, slow_cnt_d;
   logic             slow_ph_q, slow_ph_d;
   logic [FW-1:0]    fast_cnt_q, fast_cnt_d;
   logic             fast_ph_q, fast_ph_d;
   logic [N_LED-1:0] flash_act_s;
   logic [N_LED-1:0] pat_s;
   logic [N_LED-1:0] led_q;

   assign tick_s = (presc_q == PRESC_LAST);

   // Prescaler next state: free-running 0..TICK_DIV-1.
   always_comb begin
      if (tick_s) begin
         presc_d = {PW{1'b0}};
      end else begin
         presc_d = presc_q + PW'(1);
      end
   end

   // Slow blink phase: toggles after SLOW_HALF_MS ticks.
   always_comb begin
      slow_cnt_d = slow_cnt_q;
      slow_ph_d  = slow_ph_q;
      if (tick_s) begin
         if (slow_cnt_q == SLOW_LAST) begin
            slow_cnt_d = {SW{1'b0}};
            slow_ph_d  = ~slow_ph_q;
         end else begin
            slow_cnt_d = slow_cnt_q + SW'(1);
         end
      end else begin
         slow_cnt_d = slow_cnt_q;
      end
   end

   // Fast blink phase: toggles after FAST_HALF_MS ticks.
   always_comb begin
      fast_cnt_d = fast_cnt_q;
      fast_ph_d  = fast_ph_q;
      if (tick_s) begin
         if (fast_cnt_q == FAST_LAST) begin
            fast_cnt_d = {FW{1'b0}};
            fast_ph_d  = ~fast_ph_q;
         end else begin
            fast_cnt_d = fast_cnt_q + FW'(1);
         end
      end else begin
         fast_cnt_d = fast_cnt_q;
      end
   end

   // Shared timebase registers: prescaler and both phase generators.
   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         presc_q    <= {PW{1'b0}};
         slow_cnt_q <= {SW{1'b0}};
         slow_ph_q  <= 1'b0;
         fast_cnt_q <= {FW{1'b0}};
         fast_ph_q  <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         slow_cnt_q <= slow_cnt_d;
         slow_ph_q  <= slow_ph_d;
         fast_cnt_q <= fast_cnt_d;
         fast_ph_q  <= fast_ph_d;
      end
   end

   if (FLASH_MS > 0) begin : g_flash
      localparam logic [LW-1:0] FLASH_LD = LW'(FLASH_MS);

      logic [N_LED-1:0][LW-1:0] flash_q, flash_d;

      // Flash stretcher next state: a strobe reloads and beats a same-cycle tick.
      always_comb begin
         flash_d = flash_q;
         for (int i = 0; i < N_LED; i++) begin
            if (in_flash[i]) begin
               flash_d[i] = FLASH_LD;
            end else if (tick_s && (flash_q[i] != {LW{1'b0}})) begin
               flash_d[i] = flash_q[i] - LW'(1);
            end else begin
               flash_d[i] = flash_q[i];
            end
         end
      end

      // Flash stretcher registers.
      always_ff @(posedge in_clk or negedge in_rst) begin
         if (!in_rst) begin
            flash_q <= {(N_LED*LW){1'b0}};
         end else begin
            flash_q <= flash_d;
         end
      end

      // Flash is active while the stretcher has ticks left.
      always_comb begin
         flash_act_s = {N_LED{1'b0}};
         for (int i = 0; i < N_LED; i++) begin
            flash_act_s[i] = (flash_q[i] != {LW{1'b0}});
         end
      end
   end else begin : g_no_flash
      // Strobes are ignored when flashing is disabled.
      assign flash_act_s = in_flash & {N_LED{1'b0}};
   end

   // Per-LED pattern select; an active flash overrides any mode.
   always_comb begin
      pat_s = {N_LED{1'b0}};
      for (int i = 0; i < N_LED; i++) begin
         if (flash_act_s[i]) begin
            pat_s[i] = 1'b1;
         end else begin
            case (in_mode[2*i +: 2])
               2'b00:   pat_s[i] = 1'b0;
               2'b01:   pat_s[i] = 1'b1;
               2'b10:   pat_s[i] = slow_ph_q;
               2'b11:   pat_s[i] = fast_ph_q;
               default: pat_s[i] = 1'b0;
            endcase
         end
      end
   end

   // Output register with polarity applied; resets to the inactive level.
   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         led_q <= POL_MASK;
      end else begin
         led_q <= pat_s ^ POL_MASK;
      end
   end

   assign o_led = led_q;

endmodule

// File: tb/tb_led_ind_drv.sv
// -----------------------------------------------------------------------------
// tb_led_ind_drv -- self-checking bench for led_ind_drv.
//
// Three instances share clock, reset and stimulus: the main configuration, an
// active-low copy (its outputs must always be the inverse of the main one) and
// a copy with flashing disabled. Expected per-cycle outputs are pushed to a
// scoreboard queue when a run is planned and popped as each cycle completes.
// -----------------------------------------------------------------------------
module tb_led_ind_drv;

   logic       in_clk;
   logic       in_rst;
   logic [3:0] in_mode;
   logic [1:0] in_flash;
   logic [1:0] led_m, led_p, led_n;

   typedef struct {
      logic [1:0] m;   // main and (inverted) active-low instance
      logic [1:0] nf;  // flash-disabled instance
   } exp_t;

   exp_t       sb[$];
   logic [3:0] md_tab [0:127];
   logic [1:0] fl_tab [0:127];
   int         n_vec = 0;
   int         n_err = 0;

   led_ind_drv #(.N_LED(2), .TICK_DIV(4), .SLOW_HALF_MS(5), .FAST_HALF_MS(2),
                 .FLASH_MS(3), .LED_ACT_LOW(0)) u_dut (
      .in_clk(in_clk), .in_rst(in_rst), .in_mode(in_mode), .in_flash(in_flash), .o_led(led_m));

   led_ind_drv #(.N_LED(2), .TICK_DIV(4), .SLOW_HALF_MS(5), .FAST_HALF_MS(2),
                 .FLASH_MS(3), .LED_ACT_LOW(1)) u_pol (
      .in_clk(in_clk), .in_rst(in_rst), .in_mode(in_mode), .in_flash(in_flash), .o_led(led_p));

   led_ind_drv #(.N_LED(2), .TICK_DIV(4), .SLOW_HALF_MS(5), .FAST_HALF_MS(2),
                 .FLASH_MS(0), .LED_ACT_LOW(0)) u_nf (
      .in_clk(in_clk), .in_rst(in_rst), .in_mode(in_mode), .in_flash(in_flash), .o_led(led_n));

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic clear_tabs(input logic [3:0] md);
      for (int i = 0; i < 128; i++) begin
         md_tab[i] = md;
         fl_tab[i] = 2'b00;
      end
   endtask

   // Hold reset for a few cycles with the table's first stimulus, release on a negedge.
   task automatic reset_release();
      @(negedge in_clk);
      in_rst   = 1'b0;
      in_mode  = md_tab[0];
      in_flash = fl_tab[0];
      repeat (2) @(negedge in_clk);
      in_rst = 1'b1;
   endtask

   // Sample k follows the k-th rising edge after release; stimulus k is then applied.
   task automatic run(input int n, input string tag);
      exp_t e;
      for (int k = 1; k <= n; k++) begin
         @(negedge in_clk);
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s scoreboard empty at cycle %0d", tag, k);
         end else begin
            e = sb.pop_front();
            chk($sformatf("%s.main[%0d]", tag, k), led_m, e.m);
            chk($sformatf("%s.actlow[%0d]", tag, k), led_p, ~e.m);
            chk($sformatf("%s.noflash[%0d]", tag, k), led_n, e.nf);
         end
         in_mode  = md_tab[k];
         in_flash = fl_tab[k];
      end
   endtask

   initial begin
      exp_t e;
      int   s, f;
      logic a0, a1, n0;

      // ---- Reset value and release ----
      in_rst   = 1'b1;
      in_mode  = 4'b0101;
      in_flash = 2'b00;
      #2 in_rst = 1'b0;
      repeat (3) @(negedge in_clk);
      chk("rst.main", led_m, 2'b00);
      chk("rst.actlow", led_p, 2'b11);
      chk("rst.noflash", led_n, 2'b00);
      in_rst = 1'b1;
      clear_tabs(4'b0101);
      for (int k = 1; k <= 3; k++) begin
         e.m = 2'b11; e.nf = 2'b11; sb.push_back(e);
      end
      run(3, "rel");

      // ---- Blink: LED0 slow (toggle every 20), LED1 fast (toggle every 8) ----
      clear_tabs(4'b1110);
      reset_release();
      for (int k = 1; k <= 90; k++) begin
         s = ((k - 1) / 20) % 2;
         f = ((k - 1) / 8) % 2;
         e.m  = {f[0], s[0]};
         e.nf = e.m;
         sb.push_back(e);
      end
      run(90, "blink");

      // ---- Asynchronous reset mid-blink (o_led currently 10) ----
      #2 in_rst = 1'b0;
      #1;
      chk("arst.main", led_m, 2'b00);
      chk("arst.actlow", led_p, 2'b11);
      chk("arst.noflash", led_n, 2'b00);

      // ---- Flash: tick-aligned (12), worst-case (9), LED1 independent (11) ----
      clear_tabs(4'b0000);
      fl_tab[3]  = 2'b01;
      fl_tab[22] = 2'b01;
      fl_tab[40] = 2'b10;
      reset_release();
      for (int k = 1; k <= 56; k++) begin
         a0 = ((k >= 5) && (k <= 16)) || ((k >= 24) && (k <= 32));
         a1 = (k >= 42) && (k <= 52);
         e.m  = {a1, a0};
         e.nf = 2'b00;
         sb.push_back(e);
      end
      run(56, "flash");

      // ---- Retrigger, then mode change to 'on' during a flash ----
      clear_tabs(4'b0000);
      fl_tab[3]  = 2'b01;
      fl_tab[9]  = 2'b01;
      fl_tab[27] = 2'b01;
      for (int k = 33; k < 128; k++) md_tab[k] = 4'b0001;
      reset_release();
      for (int k = 1; k <= 48; k++) begin
         a0 = ((k >= 5) && (k <= 20)) || (k >= 29);
         n0 = (k >= 34);
         e.m  = {1'b0, a0};
         e.nf = {1'b0, n0};
         sb.push_back(e);
      end
      run(48, "retrig");

      chk("sb.drained", 2'(sb.size() != 0), 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
